hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameter REG_AW, default 4, register-address width.
REQ-002 SHALL provide parameter STAGES, default 3, number of tracked post-ID stages (stage 0 = EXE ... stage STAGES-1 = WB), legal range 2..8.
REQ-003 SHALL provide parameter SEL_W, default 2, select width = clog2(STAGES+1).
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have inputs: id_valid 1 (ID holds a real instruction); id_wb_en 1; id_mem_read 1; id_dest REG_AW; src1 REG_AW; src2 REG_AW; two_src 1 (src2 is live); flush 1 (branch taken, squash ID); fwd_en 1 (runtime forwarding mode).
REQ-006 SHALL have outputs: stall 1 (freeze PC and IF/ID, bubble into EXE); sel_src1 SEL_W; sel_src2 SEL_W (0 = register file, k = result of stage k-1); load_use 1 (stall cause is load-use).
REQ-007 Under STATS, SHALL also have outputs stall_cnt 16 and load_use_cnt 16.

Function
REQ-008 SHALL hold per stage an entry {valid, wb_en, mem_read, dest}; every clock entry k SHALL move to k+1, and the entry leaving stage STAGES-1 SHALL be discarded.
REQ-009 Stage 0 SHALL load {id_valid, id_wb_en, id_mem_read, id_dest} when stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0, wb_en=0, mem_read=0).
REQ-010 A stage k SHALL match a source s when valid and wb_en are set, dest==s, and id_valid=1; src2 SHALL match only when two_src=1.
REQ-011 fwd_en=1: sel_srcN SHALL be k+1 for the lowest-index (youngest) matching stage k, else 0.
REQ-012 fwd_en=1: stall and load_use SHALL both be 1 when stage 0 matches src1 or src2 and has mem_read=1; all other matches SHALL be resolved by forwarding without stall.
REQ-013 fwd_en=0: sel_src1/sel_src2 SHALL be 0; stall SHALL be 1 on any match in stages 0..STAGES-2; stage STAGES-1 (WB) SHALL never stall, because the register file writes before the ID read; load_use SHALL be 0.
REQ-014 stall, load_use and sel outputs SHALL be combinational from the current entries and ID inputs, with zero-cycle latency.
REQ-015 While stall=1 and the ID inputs are held, the hazard SHALL clear once the producer advances: a load-use stall SHALL last exactly 1 cycle with fwd_en=1; with fwd_en=0, a match at stage 0 SHALL last STAGES-1 cycles.
REQ-016 flush=1 SHALL take priority over stall for stage 0 loading; stall SHALL still be driven per REQ-012/013 in that cycle.
REQ-017 A toggle of fwd_en SHALL take effect in the same cycle and SHALL not alter stored entries.
REQ-018 Bubbles and entries with wb_en=0 SHALL never match, including dest==src.

Reset
REQ-019 With rst=1 at a clock edge, all entries SHALL become bubbles, and the counters SHALL be 0 under STATS.
REQ-020 After reset, stall=0, load_use=0 and sel_src1=sel_src2=0 SHALL hold until a valid writer enters stage 0.
REQ-021 rst SHALL override flush and stall in the same cycle; reset mid-stall SHALL drop the stall on the next cycle.

Configuration
REQ-022 Macro HAZARD_SCOREBOARD_STATS_EN defined: stall_cnt SHALL increment on every clock with stall=1, and load_use_cnt on every clock with load_use=1; both SHALL saturate at 16'hFFFF and clear on rst.
REQ-023 Macro undefined: the counter ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 fwd_en=1, STAGES=3: ADD R2 (wb_en, dest=2), then ADD src1=2 -> stall=0, sel_src1=1; one cycle later with a new consumer -> sel_src1=2.
REQ-025 fwd_en=1: LDR dest=5 in stage 0, consumer src2=5, two_src=1 -> stall=1 and load_use=1 for exactly 1 cycle, then sel_src2=2 with stall=0.
REQ-026 fwd_en=0: writer dest=3 enters stage 0, consumer src1=3 held -> stall=1 for 2 cycles, then stall=0 with sel_src1=0.
REQ-027 Producers dest=7 in stages 0 and 1, consumer src1=7, fwd_en=1 -> sel_src1=1 (youngest wins); two_src=0 with src2=7 -> sel_src2=0.
REQ-028 flush=1 together with a load-use stall -> stage 0 holds a bubble next cycle; with rst=1 asserted mid-stall -> all outputs 0 the next cycle.
REQ-029 STATS build: stall held 3 cycles -> stall_cnt=3; force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW hazard scoreboard: tracks post-ID writers, drives stall and forwarding selects.
// Optional stall statistics counters: define HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int REG_AW = 4,
    parameter int STAGES = 3,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic              flush,
    input  logic              fwd_en,
    output logic              stall,
    output logic [SEL_W-1:0]  sel_src1,
    output logic [SEL_W-1:0]  sel_src2,
    output logic              load_use
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       load_use_cnt
`endif
);

    logic [STAGES-1:0] ent_valid;
    logic [STAGES-1:0] ent_wb_en;
    logic [REG_AW-1:0] ent_dest [STAGES];
    // Only EXE ever needs mem_read: once a load leaves EXE its data is forwardable.
    logic              exe_mem_read;

    logic [STAGES-1:0] match1;
    logic [STAGES-1:0] match2;
    logic              load_stall;
    logic              nofwd_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid    <= '0;
            ent_wb_en    <= '0;
            exe_mem_read <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                ent_dest[k] <= '0;
            end
        end else begin
            if (!stall && !flush) begin
                ent_valid[0] <= id_valid;
                ent_wb_en[0] <= id_wb_en;
                exe_mem_read <= id_mem_read;
                ent_dest[0]  <= id_dest;
            end else begin
                ent_valid[0] <= 1'b0;
                ent_wb_en[0] <= 1'b0;
                exe_mem_read <= 1'b0;
                ent_dest[0]  <= id_dest;
            end
            for (int k = 1; k < STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_wb_en[k] <= ent_wb_en[k-1];
                ent_dest[k]  <= ent_dest[k-1];
            end
        end
    end

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < STAGES; k++) begin
            match1[k] = id_valid && ent_valid[k] && ent_wb_en[k] && (ent_dest[k] == src1);
            match2[k] = id_valid && ent_valid[k] && ent_wb_en[k] && (ent_dest[k] == src2) && two_src;
        end
    end

    always_comb begin
        load_stall  = (match1[0] || match2[0]) && exe_mem_read;
        // WB writes the register file before ID reads it, so the last stage never stalls.
        nofwd_stall = 1'b0;
        for (int k = 0; k < STAGES - 1; k++) begin
            nofwd_stall = nofwd_stall || match1[k] || match2[k];
        end
    end

    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        stall    = 1'b0;
        load_use = 1'b0;
        if (fwd_en) begin
            // Walk oldest to youngest so the youngest producer wins.
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (match1[k]) sel_src1 = SEL_W'(k + 1);
                if (match2[k]) sel_src2 = SEL_W'(k + 1);
            end
            stall    = load_stall;
            load_use = load_stall;
        end else begin
            stall = nofwd_stall;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt    <= '0;
            load_use_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (load_use && load_use_cnt != 16'hFFFF) begin
                load_use_cnt <= load_use_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard (queue scoreboard).
module tb_hazard_scoreboard;

    localparam int REG_AW = 4;
    localparam int STAGES = 3;
    localparam int SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_wb_en, id_mem_read;
    logic [REG_AW-1:0] id_dest, src1, src2;
    logic              two_src, flush, fwd_en;
    logic              stall, load_use;
    logic [SEL_W-1:0]  sel_src1, sel_src2;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [15:0]       stall_cnt, load_use_cnt;
`endif

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(REG_AW), .STAGES(STAGES), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_wb_en    (id_wb_en),
        .id_mem_read (id_mem_read),
        .id_dest     (id_dest),
        .src1        (src1),
        .src2        (src2),
        .two_src     (two_src),
        .flush       (flush),
        .fwd_en      (fwd_en),
        .stall       (stall),
        .sel_src1    (sel_src1),
        .sel_src2    (sel_src2),
        .load_use    (load_use)
`ifdef HAZARD_SCOREBOARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .load_use_cnt(load_use_cnt)
`endif
    );

    typedef struct {
        string           tag;
        logic            stall;
        logic            load_use;
        logic [SEL_W-1:0] sel1;
        logic [SEL_W-1:0] sel2;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one ID cycle, queue its expected outputs, compare at negedge, then advance.
    task automatic step(input string tag,
                        input logic v, input logic wb, input logic mr, input logic [REG_AW-1:0] d,
                        input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b,
                        input logic two, input logic fl, input logic fw,
                        input logic e_st, input logic e_lu,
                        input logic [SEL_W-1:0] e1, input logic [SEL_W-1:0] e2);
        exp_t e;
        id_valid = v; id_wb_en = wb; id_mem_read = mr; id_dest = d;
        src1 = a; src2 = b; two_src = two; flush = fl; fwd_en = fw;
        e.tag = tag; e.stall = e_st; e.load_use = e_lu; e.sel1 = e1; e.sel2 = e2;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_stall"},    {31'd0, stall},    {31'd0, e.stall});
            check_eq({e.tag, "_load_use"}, {31'd0, load_use}, {31'd0, e.load_use});
            check_eq({e.tag, "_sel1"},     32'(sel_src1),     32'(e.sel1));
            check_eq({e.tag, "_sel2"},     32'(sel_src2),     32'(e.sel2));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
    endtask

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic              s_rst, s_valid, s_wb_en;
    logic [REG_AW-1:0] s_dest, s_src1;
    logic              s_stall, s_load_use;
    logic [3:0]        s_sel1, s_sel2;
    logic [15:0]       s_stall_cnt, s_lu_cnt;

    hazard_scoreboard #(.REG_AW(REG_AW), .STAGES(8), .SEL_W(4)) u_sat (
        .clk         (clk),
        .rst         (s_rst),
        .id_valid    (s_valid),
        .id_wb_en    (s_wb_en),
        .id_mem_read (1'b0),
        .id_dest     (s_dest),
        .src1        (s_src1),
        .src2        (4'd0),
        .two_src     (1'b0),
        .flush       (1'b0),
        .fwd_en      (1'b0),
        .stall       (s_stall),
        .sel_src1    (s_sel1),
        .sel_src2    (s_sel2),
        .load_use    (s_load_use),
        .stall_cnt   (s_stall_cnt),
        .load_use_cnt(s_lu_cnt)
    );
`endif

    initial begin
        rst = 1'b1;
        id_valid = 0; id_wb_en = 0; id_mem_read = 0; id_dest = 0;
        src1 = 0; src2 = 0; two_src = 0; flush = 0; fwd_en = 1;
`ifdef HAZARD_SCOREBOARD_STATS_EN
        s_rst = 1'b1; s_valid = 0; s_wb_en = 0; s_dest = 0; s_src1 = 0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("reset_valid_nowr", 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);

        // Forwarding distance follows the producer down the pipe.
        step("add_r2",   1, 1, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("fwd_exe",  1, 0, 0, 2, 2, 0, 0, 0, 1, 0, 0, 1, 0);
        step("fwd_mem",  1, 0, 0, 2, 2, 0, 0, 0, 1, 0, 0, 2, 0);
        step("fwd_wb",   1, 0, 0, 2, 2, 0, 0, 0, 1, 0, 0, 3, 0);
        step("fwd_gone", 1, 0, 0, 2, 2, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(3);

        // Load-use: one stall cycle, then forward from MEM.
        step("ldr5",     1, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("lu_stall", 1, 0, 0, 0, 0, 5, 1, 0, 1, 1, 1, 0, 1);
        step("lu_fwd",   1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 2);
        step("lu_novld", 0, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0);
        idle(3);

        // No forwarding: stall until the writer reaches WB.
        step("w3",     1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("nf_exe", 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        step("nf_mem", 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        step("nf_wb",  1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Youngest producer wins; dead src2 ignored; fwd_en toggles in-cycle.
        step("w7a",     1, 1, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("w7b",     1, 1, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("young",   1, 0, 0, 0, 7, 7, 0, 0, 1, 0, 0, 1, 0);
        step("tog_off", 1, 0, 0, 0, 7, 7, 0, 0, 0, 1, 0, 0, 0);
        step("tog_on",  1, 0, 0, 0, 7, 7, 0, 0, 1, 0, 0, 3, 0);
        idle(3);

        // Flush squashes ID, with and without a concurrent load-use stall.
        step("ldr5b",     1, 1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("lu_flush",  1, 1, 0, 9, 5, 0, 0, 1, 1, 1, 1, 1, 0);
        step("after_fl",  1, 0, 0, 0, 9, 5, 1, 0, 1, 0, 0, 0, 2);
        step("fl_nostal", 1, 1, 0, 10, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("after_fl2", 1, 0, 0, 0, 10, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(3);

        // Reset in the middle of a load-use stall.
        step("ldr6", 1, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        step("rst_lu", 1, 0, 0, 0, 6, 0, 0, 0, 1, 1, 1, 1, 0);
        rst = 1'b0;
        step("post_rst", 1, 0, 0, 0, 6, 0, 0, 0, 1, 0, 0, 0, 0);

`ifdef HAZARD_SCOREBOARD_STATS_EN
        rst = 1'b1;
        step("st_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        check_eq("stall_cnt_rst", 32'(stall_cnt), 32'd0);
        check_eq("lu_cnt_rst", 32'(load_use_cnt), 32'd0);
        step("st_w3",   1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("st_nf0",  1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        step("st_nf1",  1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0);
        step("st_nfwb", 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        step("st_ldr",  1, 1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("st_lu",   1, 0, 0, 0, 4, 0, 0, 0, 1, 1, 1, 1, 0);
        step("st_fwd",  1, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 2, 0);
        check_eq("stall_cnt_3", 32'(stall_cnt), 32'd3);
        check_eq("lu_cnt_1", 32'(load_use_cnt), 32'd1);

        // Eight-stage instance: 7 stall cycles per writer, 70000 in total.
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        for (int p = 0; p < 10000; p++) begin
            s_valid = 1; s_wb_en = 1; s_dest = 1; s_src1 = 2;
            @(posedge clk);
            #1;
            for (int c = 0; c < 7; c++) begin
                s_valid = 1; s_wb_en = 0; s_dest = 0; s_src1 = 1;
                @(posedge clk);
                #1;
            end
        end
        check_eq("stall_cnt_sat", 32'(s_stall_cnt), 32'h0000FFFF);
        check_eq("lu_cnt_sat0", 32'(s_lu_cnt), 32'd0);
`endif

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
